instr_encoder_loader: RTL and testbench

//  Field-level MIPS instruction encoder and sequential program loader. It is the

---
 rtl/instr_encoder_loader.sv | 152 +++++++++++++++
 tb/tb_instr_encoder_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs one MIPS instruction per valid/ready transfer (kind + fields) into a 32-bit word
//   and writes it to instruction memory at consecutive word addresses, one cycle later.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start, base_addr    open a load session at base_addr (word aligned)
//   in_valid/in_ready   instruction handshake; in_last marks the final instruction
//   in_kind, in_*       instruction kind and fields
//   mem_we/addr/wdata   instruction memory write port
//   count, done         words written this session, session complete level
//   err_illegal         one-cycle pulse when an illegal kind is accepted and dropped
module instr_encoder_loader #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 64,
    localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [CntW-1:0]   count,
    output logic              done,
    output logic              err_illegal
);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        xfer;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        if (in_kind[3]) begin
            enc_legal = 1'b0;
        end else begin
            unique case (in_kind[2:0])
                3'd0: enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
                3'd1: enc_word = {6'b000010, in_target};
                3'd2: enc_word = {6'b000100, in_rs, in_rt, in_imm};
                3'd3: enc_word = {6'b000101, in_rs, in_rt, in_imm};
                3'd4: enc_word = {6'b001000, in_rs, in_rt, in_imm};
                3'd5: enc_word = {6'b001100, in_rs, in_rt, in_imm};
                3'd6: enc_word = {6'b100011, in_rs, in_rt, in_imm};
                3'd7: enc_word = {6'b101011, in_rs, in_rt, in_imm};
                default: enc_word = '0;
            endcase
        end
    end

    // A pending registered word already counts against capacity; once the last
    // instruction is taken nothing more is accepted while its write drains.
    assign in_ready = (state_q == StLoad) && !last_q && !reset &&
                      ((32'(count_q) + 32'(we_q)) < DEPTH);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        last_d  = last_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;

        if (we_q) count_d = count_q + 1'b1;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StLoad;
                    ptr_d   = {base_addr[ADDR_W-1:2], 2'b00};
                    count_d = '0;
                    last_d  = 1'b0;
                end
            end
            StLoad: begin
                if (we_q && (last_q || (32'(count_q) + 32'd1 == DEPTH))) state_d = StDone;
                if (xfer) begin
                    if (enc_legal) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = enc_word;
                        ptr_d   = ptr_q + ADDR_W'(4);
                        last_d  = in_last;
                    end else begin
                        err_d = 1'b1;
                        // Illegal final instruction has no write to wait for.
                        if (in_last) state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Reset suppresses a write already registered so it never reaches memory.
    assign mem_we      = we_q && !reset;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign count       = count_q;
    assign done        = (state_q == StDone);
    assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CntW   = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [3:0]        in_kind;
    logic [4:0]        in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [CntW-1:0]   count;
    logic              done;
    logic              err_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .done(done), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                             input logic [15:0] imm, input logic [25:0] tgt, input logic last);
        in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_funct = fn; in_imm = imm; in_target = tgt; in_last = last;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; start = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic open_session(input logic [ADDR_W-1:0] b);
        base_addr = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; base_addr = '0;
        set_instr(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
        tick(); tick();
        n_checks++;
        if ({mem_we, done, err_illegal, in_ready} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got %b want 0000", {mem_we, done, err_illegal, in_ready});
        end
        n_checks++;
        if (count !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++; $display("FAIL reset_data got cnt=%0d addr=%h wdata=%h want 0", count, mem_addr, mem_wdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_rtype();
        do_reset();
        open_session(32'h0000_0043);
        set_instr(4'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
        in_valid = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rtype_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h012A4020) begin
            n_fail++;
            $display("FAIL rtype_write got we=%b addr=%h wdata=%h want 1 00000040 012a4020",
                     mem_we, mem_addr, mem_wdata);
        end
        tick();
        n_checks++;
        if (mem_we !== 1'b0 || count !== 3'd1 || done !== 1'b0) begin
            n_fail++; $display("FAIL rtype_after got we=%b cnt=%0d done=%b want 0 1 0", mem_we, count, done);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        open_session(32'h40);
        in_valid = 1'b1;
        set_instr(4'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0);
        tick();
        set_instr(4'd6, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0, 1'b1);
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h20080005) begin
            n_fail++; $display("FAIL b2b_addi got we=%b addr=%h wdata=%h want 1 00000040 20080005",
                               mem_we, mem_addr, mem_wdata);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h44 || mem_wdata !== 32'h8D090004) begin
            n_fail++; $display("FAIL b2b_lw got we=%b addr=%h wdata=%h want 1 00000044 8d090004",
                               mem_we, mem_addr, mem_wdata);
        end
        n_checks++;
        if (in_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_mid got ready=%b done=%b want 0 0", in_ready, done);
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || count !== 3'd2 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL b2b_done got done=%b cnt=%0d we=%b want 1 2 0", done, count, mem_we);
        end
    endtask

    task automatic test_branch_jump();
        // start in DONE opens a fresh session
        open_session(32'h100);
        n_checks++;
        if (done !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL restart got done=%b cnt=%0d want 0 0", done, count);
        end
        in_valid = 1'b1;
        set_instr(4'd2, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
        tick();
        set_instr(4'd1, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1);
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'h1109FFFF) begin
            n_fail++; $display("FAIL beq got we=%b addr=%h wdata=%h want 1 00000100 1109ffff",
                               mem_we, mem_addr, mem_wdata);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h104 || mem_wdata !== 32'h08000010) begin
            n_fail++; $display("FAIL jump got we=%b addr=%h wdata=%h want 1 00000104 08000010",
                               mem_we, mem_addr, mem_wdata);
        end
        tick();
    endtask

    task automatic test_capacity();
        int writes = 0;
        int accepts = 0;
        do_reset();
        open_session(32'h80);
        set_instr(4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'd0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 6);
            if (in_valid && in_ready) accepts++;
            if (c == 4) begin
                n_checks++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL cap_ready4 got %b want 0", in_ready); end
            end
            tick();
            if (mem_we) begin
                n_checks++;
                if (mem_addr !== 32'h80 + 32'(4 * writes) || mem_wdata !== 32'h302200FF) begin
                    n_fail++; $display("FAIL cap_write%0d got addr=%h wdata=%h want %h 302200ff",
                                       writes, mem_addr, mem_wdata, 32'h80 + 32'(4 * writes));
                end
                writes++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (writes != 4 || accepts != 4) begin
            n_fail++; $display("FAIL cap_total got writes=%0d accepts=%0d want 4 4", writes, accepts);
        end
        n_checks++;
        if (done !== 1'b1 || count !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL cap_done got done=%b cnt=%0d ready=%b want 1 4 0", done, count, in_ready);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        open_session(32'h40);
        in_valid = 1'b1;
        set_instr(4'd4, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'd1, 26'd0, 1'b0);
        tick();
        set_instr(4'd9, 5'd3, 5'd3, 5'd3, 5'd3, 6'd3, 16'd3, 26'd3, 1'b0);
        tick();
        // start while loading must not move the pointer
        start = 1'b1; base_addr = 32'h200;
        n_checks++;
        if (err_illegal !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL ill_pulse got err=%b we=%b want 1 0", err_illegal, mem_we);
        end
        set_instr(4'd4, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'd2, 26'd0, 1'b1);
        tick();
        start = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h44 || mem_wdata !== 32'h20010002 || err_illegal !== 1'b0) begin
            n_fail++; $display("FAIL ill_next got we=%b addr=%h wdata=%h err=%b want 1 00000044 20010002 0",
                               mem_we, mem_addr, mem_wdata, err_illegal);
        end
        tick();
        n_checks++;
        if (count !== 3'd2 || done !== 1'b1) begin
            n_fail++; $display("FAIL ill_count got cnt=%0d done=%b want 2 1", count, done);
        end
        // illegal final instruction: done next cycle, no write
        open_session(32'h0);
        in_valid = 1'b1;
        set_instr(4'd12, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (done !== 1'b1 || err_illegal !== 1'b1 || mem_we !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL ill_last got done=%b err=%b we=%b cnt=%0d want 1 1 0 0",
                               done, err_illegal, mem_we, count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        open_session(32'h40);
        in_valid = 1'b1;
        set_instr(4'd7, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h10, 26'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rmid_we got %b want 0", mem_we); end
        tick();
        reset = 1'b0;
        n_checks++;
        if ({mem_we, done, err_illegal, in_ready} !== 4'b0000 || count !== '0 ||
            mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++; $display("FAIL rmid_zero got we=%b done=%b err=%b rdy=%b cnt=%0d addr=%h wdata=%h want 0",
                               mem_we, done, err_illegal, in_ready, count, mem_addr, mem_wdata);
        end
        in_valid = 1'b1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_idle_ready got %b want 0", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rmid_idle_we got %b want 0", mem_we); end
        open_session(32'h40);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hAC430010) begin
            n_fail++; $display("FAIL rmid_resume got we=%b addr=%h wdata=%h want 1 00000040 ac430010",
                               mem_we, mem_addr, mem_wdata);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_back_to_back();
        test_branch_jump();
        test_capacity();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
